// File: rtl/traffic_pkg.sv
// Shared definitions for the cyclic lamp sequencer and the lamp output driver:
// light codes, driver states, fault causes and the legal-successor function.
package traffic_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] RED    = 3'b000;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_ORDER   = 2'd2;
    localparam logic [1:0] FC_DWELL   = 2'd3;

    typedef struct packed {
        logic red;
        logic green;
        logic yellow;
    } lamps_t;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == RED) || (code == GREEN) || (code == YELLOW);
    endfunction

    // Legal successor in the RED -> GREEN -> YELLOW -> RED cycle. Illegal codes
    // map to RED; callers screen legality before asking for a successor.
    function automatic logic [2:0] next_light(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            RED:     nxt = GREEN;
            GREEN:   nxt = YELLOW;
            default: nxt = RED;
        endcase
        return nxt;
    endfunction

    function automatic lamps_t decode_lamps(input logic [2:0] code);
        lamps_t l;
        l = '0;
        case (code)
            GREEN:   l.green  = 1'b1;
            YELLOW:  l.yellow = 1'b1;
            default: l.red    = 1'b1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/lamp_blinker.sv
// Enable-gated flash divider. The level starts high on the cycle enable rises
// and toggles every BLINK_HALF enabled cycles; it is held low while disabled.
module lamp_blinker
    import traffic_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic level_next_o
);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BLINK_HALF - 1);

    logic             en_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Next count and level; restart on enable rising, toggle on counter wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!en_i) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (!en_q) begin
            cnt_d   = '0;
            level_d = 1'b1;
        end else if (cnt_q == LAST_C) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            en_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            en_q    <= en_i;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // The owner registers this into its lamp output alongside the other lamps.
    assign level_next_o = level_d;

endmodule

// File: rtl/lamp_output_driver.sv
// Lamp output driver: decodes the sequencer light code into registered one-hot
// lamps and supervises the stream for illegal codes, out-of-order changes and
// dwell violations. A fault latches its first cause and flashes yellow until
// fault_clr arrives while the sequencer shows RED.
module lamp_output_driver
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_DWELL  = 1,
    parameter int unsigned BLINK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:2] light_in,
    input  logic       fault_clr,
    output logic       lamp_red,
    output logic       lamp_green,
    output logic       lamp_yellow,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [CNT_W-1:0] MIN_DWELL_C = CNT_W'(MIN_DWELL);

    logic [2:0]       light_code;
    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic             fault_q, fault_d;
    lamps_t           lamps_q, lamps_d;
    logic             blink_en;
    logic             blink_level_d;

    // light_in is numbered [0:2] with bit 0 as MSB; this keeps that ordering.
    assign light_code = light_in;

    // Next-state logic: supervision in RUN, exit check in FAULT.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        dwell_d      = dwell_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            INIT: begin
                if (!is_legal(light_code)) begin
                    state_d      = FAULT;
                    fault_code_d = FC_ILLEGAL;
                end else if (light_code == RED) begin
                    state_d = RUN;
                    prev_d  = RED;
                    dwell_d = 8'd1;
                end
            end
            RUN: begin
                if (!is_legal(light_code)) begin
                    state_d      = FAULT;
                    fault_code_d = FC_ILLEGAL;
                end else if (light_code != prev_q) begin
                    if (light_code != next_light(prev_q)) begin
                        state_d      = FAULT;
                        fault_code_d = FC_ORDER;
                    end else if (dwell_q < MIN_DWELL_C) begin
                        state_d      = FAULT;
                        fault_code_d = FC_DWELL;
                    end else begin
                        prev_d  = light_code;
                        dwell_d = 8'd1;
                    end
                end else if (dwell_q < MIN_DWELL_C) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr && (light_code == RED)) begin
                    state_d      = RUN;
                    prev_d       = RED;
                    dwell_d      = 8'd1;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign blink_en = (state_d == FAULT);

    lamp_blinker #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blinker (
        .clk          (clk),
        .rst          (rst),
        .en_i         (blink_en),
        .level_next_o (blink_level_d)
    );

    // Output decode from the next state so every output is a flop.
    always_comb begin
        lamps_d = '{red: 1'b1, green: 1'b0, yellow: 1'b0};
        fault_d = 1'b0;
        unique case (state_d)
            RUN:   lamps_d = decode_lamps(prev_d);
            FAULT: begin
                lamps_d = '{red: 1'b0, green: 1'b0, yellow: blink_level_d};
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            prev_q       <= RED;
            dwell_q      <= '0;
            fault_code_q <= FC_NONE;
            fault_q      <= 1'b0;
            lamps_q      <= '{red: 1'b1, green: 1'b0, yellow: 1'b0};
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            dwell_q      <= dwell_d;
            fault_code_q <= fault_code_d;
            fault_q      <= fault_d;
            lamps_q      <= lamps_d;
        end
    end

    assign lamp_red    = lamps_q.red;
    assign lamp_green  = lamps_q.green;
    assign lamp_yellow = lamps_q.yellow;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule
